// File: rtl/tb_irq_gen_if.sv
// Command bus between the bench command source and the multi-channel IRQ generator.
interface tb_irq_gen_if #(
    parameter int CHANNELS = 4,
    parameter int DELAY_W  = 16,
    parameter int PULSE_W  = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic [CH_W-1:0]    i_cmd_channel;
    logic [1:0]         i_cmd_mode;
    logic [DELAY_W-1:0] i_cmd_delay;
    logic [PULSE_W-1:0] i_cmd_width;

    modport master (
        output i_cmd_valid, i_cmd_channel, i_cmd_mode, i_cmd_delay, i_cmd_width,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid, i_cmd_channel, i_cmd_mode, i_cmd_delay, i_cmd_width,
        output o_cmd_ready
    );
endinterface

// File: rtl/tb_irq_gen.sv
// Multi-channel interrupt generator: per-channel start delay, then a level IRQ held
// until ack or a fixed-length pulse; acks outside an asserted IRQ are flagged sticky.
module tb_irq_gen #(
    parameter int CHANNELS = 4,
    parameter int DELAY_W  = 16,
    parameter int PULSE_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    tb_irq_gen_if.slave         cmd,
    input  logic [CHANNELS-1:0] i_ack,
    output logic [CHANNELS-1:0] o_irq,
    output logic [CHANNELS-1:0] o_busy,
    output logic [CHANNELS-1:0] o_spurious_ack
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (DELAY_W > PULSE_W) ? DELAY_W : PULSE_W;

    localparam logic [1:0] MODE_LEVEL = 2'd0;
    localparam logic [1:0] MODE_PULSE = 2'd1;
    localparam logic [1:0] MODE_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ASSERT
    } state_t;

    state_t                           r_state [CHANNELS];
    logic   [CHANNELS-1:0][CNT_W-1:0] r_cnt;
    logic   [CHANNELS-1:0][PULSE_W-1:0] r_width;
    logic   [CHANNELS-1:0]            r_pulse;
    logic   [CHANNELS-1:0]            r_irq;
    logic   [CHANNELS-1:0]            r_spur;

    state_t                           w_state_nxt [CHANNELS];
    logic   [CHANNELS-1:0][CNT_W-1:0] w_cnt_nxt;
    logic   [CHANNELS-1:0][PULSE_W-1:0] w_width_nxt;
    logic   [CHANNELS-1:0]            w_pulse_nxt;
    logic   [CHANNELS-1:0]            w_irq_nxt;
    logic   [CHANNELS-1:0]            w_spur_set;

    logic [31:0] w_ch_ext;
    logic        w_ch_ok;
    logic        w_tgt_idle;
    logic        w_ready;
    logic        w_accept;

    assign w_ch_ext = 32'(cmd.i_cmd_channel);
    assign w_ch_ok  = (w_ch_ext < 32'(CHANNELS));

    always_comb begin
        w_tgt_idle = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cmd.i_cmd_channel == CH_W'(c)) begin
                w_tgt_idle = (r_state[c] == ST_IDLE);
            end
        end
    end

    // CLEAR and out-of-range targets never stall the source.
    assign w_ready          = (cmd.i_cmd_mode == MODE_CLEAR) || !w_ch_ok || w_tgt_idle;
    assign cmd.o_cmd_ready  = w_ready;
    assign w_accept         = cmd.i_cmd_valid && w_ready;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            logic w_hit;
            w_state_nxt[c] = r_state[c];
            w_cnt_nxt[c]   = r_cnt[c];
            w_width_nxt[c] = r_width[c];
            w_pulse_nxt[c] = r_pulse[c];
            w_irq_nxt[c]   = r_irq[c];
            w_spur_set[c]  = i_ack[c] && (r_state[c] != ST_ASSERT);
            w_hit          = w_accept && w_ch_ok && (cmd.i_cmd_channel == CH_W'(c));

            case (r_state[c])
                ST_IDLE: begin
                    if (w_hit && (cmd.i_cmd_mode == MODE_LEVEL || cmd.i_cmd_mode == MODE_PULSE)) begin
                        w_state_nxt[c] = ST_WAIT;
                        w_cnt_nxt[c]   = CNT_W'(cmd.i_cmd_delay);
                        w_width_nxt[c] = cmd.i_cmd_width;
                        w_pulse_nxt[c] = (cmd.i_cmd_mode == MODE_PULSE);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt[c] == '0) begin
                        w_state_nxt[c] = ST_ASSERT;
                        w_irq_nxt[c]   = 1'b1;
                        // Pulse counter holds remaining high cycles after this one.
                        if (r_pulse[c] && (r_width[c] != '0)) begin
                            w_cnt_nxt[c] = CNT_W'(r_width[c] - PULSE_W'(1));
                        end else begin
                            w_cnt_nxt[c] = '0;
                        end
                    end else begin
                        w_cnt_nxt[c] = r_cnt[c] - CNT_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (!r_pulse[c]) begin
                        if (i_ack[c]) begin
                            w_state_nxt[c] = ST_IDLE;
                            w_irq_nxt[c]   = 1'b0;
                        end
                    end else if (r_cnt[c] == '0) begin
                        w_state_nxt[c] = ST_IDLE;
                        w_irq_nxt[c]   = 1'b0;
                    end else begin
                        w_cnt_nxt[c] = r_cnt[c] - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt[c] = ST_IDLE;
                    w_irq_nxt[c]   = 1'b0;
                end
            endcase

            if (w_hit && (cmd.i_cmd_mode == MODE_CLEAR)) begin
                w_state_nxt[c] = ST_IDLE;
                w_cnt_nxt[c]   = '0;
                w_irq_nxt[c]   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= ST_IDLE;
            end
            r_cnt   <= '0;
            r_width <= '0;
            r_pulse <= '0;
            r_irq   <= '0;
            r_spur  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= w_state_nxt[c];
            end
            r_cnt   <= w_cnt_nxt;
            r_width <= w_width_nxt;
            r_pulse <= w_pulse_nxt;
            r_irq   <= w_irq_nxt;
            r_spur  <= r_spur | w_spur_set;
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            o_busy[c] = (r_state[c] != ST_IDLE);
        end
    end

    assign o_irq          = r_irq;
    assign o_spurious_ack = r_spur;
endmodule
